// File: rtl/prog_loader_pkg.sv
// Shared state encodings and header field widths for the program loader.
package prog_loader_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CSUM   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  localparam int LEN_W  = 12;
  localparam int BYTE_W = 8;

  // States in which a host byte can be taken.
  function automatic logic frame_active(input logic [2:0] s);
    return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DATA) || (s == S_CSUM);
  endfunction

endpackage

// File: rtl/prog_loader_load_timer.sv
// Idle counter: expires after TIMEOUT consecutive enabled cycles without clear.
module load_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Expiry fires in the TIMEOUT-th idle cycle so the FSM leaves on that edge.
  assign expired_o = (TIMEOUT != 0) && enable_i && !clear_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || !enable_i) cnt_d = '0;
    else if (!expired_o && TIMEOUT != 0) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream program loader: length header, payload, checksum.
// Handshake: a byte transfers on a rising edge where in_valid && in_ready.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                TIMEOUT   = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2:0]        dbg_state
);
  logic [2:0]        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [BYTE_W-1:0] sum_q, sum_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              core_rst_q, core_rst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              accept;
  logic              expired;

  assign in_ready   = frame_active(state_q);
  assign accept     = in_valid && in_ready;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign core_reset = core_rst_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign dbg_state  = state_q;

  load_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clock     (clock),
    .reset     (reset),
    .clear_i   (accept),
    .enable_i  (in_ready),
    .expired_o (expired)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    core_rst_d = core_rst_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;

    case (state_q)
      S_LEN_HI: if (accept) begin
        sum_d        = sum_q + in_data;
        len_d[11:8]  = in_data[3:0];
        state_d      = (in_data[7:4] != 4'd0) ? S_ERROR : S_LEN_LO;
      end
      S_LEN_LO: if (accept) begin
        sum_d       = sum_q + in_data;
        len_d[7:0]  = in_data;
        state_d     = ({len_q[11:8], in_data} == '0) ? S_CSUM : S_DATA;
      end
      S_DATA: if (accept) begin
        sum_d   = sum_q + in_data;
        we_d    = 1'b1;
        wdata_d = in_data;
        addr_d  = BASE_ADDR + ADDR_W'(idx_q);
        idx_d   = idx_q + 1'b1;
        if (idx_q == len_q - 1'b1) state_d = S_CSUM;
      end
      S_CSUM: if (accept) state_d = (in_data == sum_q) ? S_DONE : S_ERROR;
      default: if (start) begin
        state_d    = S_LEN_HI;
        len_d      = '0;
        idx_d      = '0;
        sum_d      = '0;
        core_rst_d = 1'b1;
        busy_d     = 1'b1;
        done_d     = 1'b0;
        error_d    = 1'b0;
      end
    endcase

    if (expired) state_d = S_ERROR;

    // Status flags are registered on the edge that enters DONE/ERROR.
    if (in_ready && state_d == S_DONE) begin
      done_d     = 1'b1;
      busy_d     = 1'b0;
      core_rst_d = 1'b0;
    end
    if (in_ready && state_d == S_ERROR) begin
      error_d = 1'b1;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      sum_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= '0;
      core_rst_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      core_rst_q <= core_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// Randomized and directed bench for prog_loader against a frame-level model.
module tb_prog_loader;
  localparam int ADDR_W = 12;
  localparam logic [ADDR_W-1:0] BASE = 12'h000;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready, mem_we, core_reset, busy, done, error;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [2:0]        dbg_state;

  int errors = 0;
  int checks = 0;

  logic [ADDR_W+7:0] exp_q[$];
  logic [7:0]        frm_data[$];
  logic              cur_is_data = 1'b0;
  logic              we_exp;

  prog_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_reset(core_reset),
    .busy(busy), .done(done), .error(error), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // A data byte accepted on an edge must appear as a write in the following cycle.
  always @(posedge clock or negedge reset) begin
    if (!reset) we_exp <= 1'b0;
    else        we_exp <= in_valid && in_ready && cur_is_data;
  end

  // scoreboard
  always @(negedge clock) begin
    if (reset && (mem_we || we_exp)) begin
      chk("we_strobe", {31'd0, mem_we}, {31'd0, we_exp});
      if (mem_we && we_exp) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'd1, 32'd0);
        end else begin
          logic [ADDR_W+7:0] e;
          e = exp_q.pop_front();
          chk("wr_addr", {20'd0, mem_addr}, {20'd0, e[ADDR_W+7:8]});
          chk("wr_data", {24'd0, mem_wdata}, {24'd0, e[7:0]});
        end
      end
    end
  end

  // drivers
  task automatic pulse_start();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input logic is_data);
    bit got;
    got = 1'b0;
    repeat (gap) begin @(posedge clock); #1; end
    in_valid = 1'b1;
    in_data = b;
    cur_is_data = is_data;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge clock);
      if (in_ready) begin
        @(posedge clock); #1;
        got = 1'b1;
      end
    end
    in_valid = 1'b0;
    in_data = $urandom_range(0, 255);
    cur_is_data = 1'b0;
    if (!got) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_outcome(input string tag, input logic exp_done);
    @(posedge clock); @(negedge clock);
    chk({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
    chk({tag, "_error"}, {31'd0, error}, {31'd0, !exp_done});
    chk({tag, "_core_reset"}, {31'd0, core_reset}, {31'd0, !exp_done});
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_q_left"}, exp_q.size(), 32'd0);
  endtask

  // Frame model: bad header ends after one byte; otherwise every payload byte is
  // written at BASE+i and the frame succeeds iff csum is the 8-bit sum of all bytes.
  task automatic run_frame(input string tag, input logic [7:0] hi, input logic [7:0] lo,
                           input logic [7:0] csum, input int gap_max);
    int len;
    logic [7:0] sum;
    len = {hi[3:0], lo};
    pulse_start();
    if (hi[7:4] != 4'd0) begin
      send_byte(hi, $urandom_range(0, gap_max), 1'b0);
      check_outcome(tag, 1'b0);
      return;
    end
    sum = hi + lo;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({BASE + ADDR_W'(i), frm_data[i]});
      sum = sum + frm_data[i];
    end
    send_byte(hi, $urandom_range(0, gap_max), 1'b0);
    send_byte(lo, $urandom_range(0, gap_max), 1'b0);
    for (int i = 0; i < len; i++) send_byte(frm_data[i], $urandom_range(0, gap_max), 1'b1);
    send_byte(csum, $urandom_range(0, gap_max), 1'b0);
    check_outcome(tag, csum == sum);
  endtask

  task automatic load_abc();
    frm_data.delete();
    frm_data.push_back(8'hA1); frm_data.push_back(8'hB2); frm_data.push_back(8'hC3);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_core_reset", {31'd0, core_reset}, 32'd1);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {20'd0, mem_addr}, {20'd0, BASE});
    reset = 1'b1;

    load_abc();
    run_frame("good", 8'h00, 8'h03, 8'h19, 0);
    run_frame("bad_csum", 8'h00, 8'h03, 8'h18, 0);
    frm_data.delete();
    run_frame("zero_len", 8'h00, 8'h00, 8'h00, 0);
    run_frame("bad_hdr", 8'h10, 8'h00, 8'h00, 0);

    // fixed gaps of five idle cycles stay inside the timeout window
    load_abc();
    pulse_start();
    foreach (frm_data[i]) exp_q.push_back({BASE + ADDR_W'(i), frm_data[i]});
    send_byte(8'h00, 5, 1'b0);
    send_byte(8'h03, 5, 1'b0);
    foreach (frm_data[i]) send_byte(frm_data[i], 5, 1'b1);
    send_byte(8'h19, 5, 1'b0);
    check_outcome("gap5", 1'b1);

    // stall after the length: still busy after 15 idle cycles, error on the 16th
    pulse_start();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h03, 0, 1'b0);
    repeat (15) @(posedge clock);
    @(negedge clock);
    chk("to_busy_15", {31'd0, busy}, 32'd1);
    chk("to_error_15", {31'd0, error}, 32'd0);
    @(posedge clock); @(negedge clock);
    chk("to_error_16", {31'd0, error}, 32'd1);
    chk("to_busy_16", {31'd0, busy}, 32'd0);
    chk("to_core_reset", {31'd0, core_reset}, 32'd1);

    // reset after two data bytes: third byte never written, core held in reset
    load_abc();
    pulse_start();
    exp_q.push_back({BASE, 8'hA1});
    exp_q.push_back({BASE + 12'd1, 8'hB2});
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h03, 0, 1'b0);
    send_byte(8'hA1, 0, 1'b1);
    send_byte(8'hB2, 0, 1'b1);
    @(posedge clock); #1 reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("mid_rst_core_reset", {31'd0, core_reset}, 32'd1);
    chk("mid_rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_q_left", exp_q.size(), 32'd0);
    #1 reset = 1'b1;
    repeat (4) @(posedge clock);
    run_frame("reload", 8'h00, 8'h03, 8'h19, 0);

    // random frames
    for (int f = 0; f < 24; f++) begin
      int len;
      logic [7:0] hi, lo, s, cs;
      len = $urandom_range(0, 24);
      hi = ($urandom_range(0, 7) == 0) ? 8'(8'h10 * $urandom_range(1, 15)) : 8'h00;
      lo = 8'(len);
      frm_data.delete();
      s = hi + lo;
      for (int i = 0; i < len; i++) begin
        frm_data.push_back(8'($urandom_range(0, 255)));
        s = s + frm_data[i];
      end
      cs = ($urandom_range(0, 3) == 0) ? (s ^ 8'($urandom_range(1, 255))) : s;
      run_frame("rand", hi, lo, cs, 6);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
